// File: rtl/serial_compare_ctrl.sv
// Serial unsigned magnitude comparator: walks 2-bit slices MSB first through one
// shared slice comparator and hands off G/E/L plus the slice count over valid/ready.
module serial_compare_ctrl #(
    parameter int nb = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [nb-1:0]          A,
    input  logic [nb-1:0]          B,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   G,
    output logic                   E,
    output logic                   L,
    output logic [$clog2(nb/2):0]  slices,
    output logic                   busy
);

    localparam int ns = nb / 2;
    localparam int SW = $clog2(ns) + 1;
    localparam int IW = (ns > 1) ? $clog2(ns) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [nb-1:0]   a_q, a_d, b_q, b_d;
    logic            g_q, g_d, e_q, e_d, l_q, l_d;
    logic [SW-1:0]   slices_q, slices_d;
    logic [1:0]      a_sl, b_sl;
    logic [2:0]      gel;

    // Single 2-bit magnitude slice, returned as {g, e, l}.
    function automatic logic [2:0] cmp2(input logic [1:0] a, input logic [1:0] b);
        return {a > b, a == b, a < b};
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        g_d      = g_q;
        e_d      = e_q;
        l_d      = l_q;
        slices_d = slices_q;
        a_sl     = a_q[{idx_q, 1'b0} +: 2];
        b_sl     = b_q[{idx_q, 1'b0} +: 2];
        gel      = cmp2(a_sl, b_sl);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    idx_d    = IW'(ns - 1);
                    g_d      = 1'b0;
                    e_d      = 1'b0;
                    l_d      = 1'b0;
                    slices_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                slices_d = slices_q + SW'(1);
                // Abort outranks a compare that would otherwise terminate this cycle.
                if (abort) begin
                    g_d     = 1'b0;
                    e_d     = 1'b0;
                    l_d     = 1'b0;
                    state_d = IDLE;
                end else if (gel[2] || gel[0]) begin
                    g_d     = gel[2];
                    e_d     = 1'b0;
                    l_d     = gel[0];
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    g_d     = 1'b0;
                    e_d     = 1'b1;
                    l_d     = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= IW'(ns - 1);
            a_q      <= '0;
            b_q      <= '0;
            g_q      <= 1'b0;
            e_q      <= 1'b0;
            l_q      <= 1'b0;
            slices_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            g_q      <= g_d;
            e_q      <= e_d;
            l_q      <= l_d;
            slices_q <= slices_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign G         = g_q;
    assign E         = e_q;
    assign L         = l_q;
    assign slices    = slices_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl (nb=8): directed operand pairs with
// hand-computed results, a monitor that checks every handed-off result.
module tb_serial_compare_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A, B;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic       G, E, L;
    logic [2:0] slices;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    logic [5:0] exp_q[$];

    serial_compare_ctrl #(.nb(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
        .G(G), .E(E), .L(L), .slices(slices), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every result taken by the consumer must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=GEL_S=0x%0h required=none", {G, E, L, slices});
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("result_GEL_slices", {26'd0, G, E, L, slices}, {26'd0, e});
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) check({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic rdy);
        A = a; B = b; in_valid = 1'b1; out_ready = rdy;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles from the accepting edge until out_valid is seen.
    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (out_valid !== 1'b1 && lat < 20);
        if (out_valid !== 1'b1) check({name, "_valid_timeout"}, 0, 1);
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] gel, input int k);
        int lat;
        wait_ready(name);
        exp_q.push_back({gel, 3'(k)});
        accept(a, b, 1'b1);
        wait_valid(name, lat);
        check({name, "_latency"}, lat, k);
        @(posedge clk); #1;
        check({name, "_back_to_idle"}, {in_ready, busy, out_valid}, 3'b100);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; abort = 1'b0; out_ready = 1'b0;
        #12;
        check("reset_state", {in_ready, out_valid, busy, G, E, L, slices}, 9'b100_000_000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("c5_35", 8'hC5, 8'h35, 3'b100, 1);
        check("idle_keeps_result", {G, E, L}, 3'b100);
        run_op("5a_5a", 8'h5A, 8'h5A, 3'b010, 4);
        run_op("12_13", 8'h12, 8'h13, 3'b001, 4);
        run_op("92_82", 8'h92, 8'h82, 3'b100, 2);
        run_op("40_80", 8'h40, 8'h80, 3'b001, 1);
        run_op("0c_08", 8'h0C, 8'h08, 3'b100, 3);
        run_op("ff_fe", 8'hFF, 8'hFE, 3'b100, 4);
        run_op("00_00", 8'h00, 8'h00, 3'b010, 4);

        // Backpressure: result held while new operands are offered and ignored.
        wait_ready("bp");
        exp_q.push_back({3'b100, 3'd2});
        accept(8'h30, 8'h20, 1'b0);
        wait_valid("bp", lat);
        check("bp_latency", lat, 2);
        A = 8'h01; B = 8'h02; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {G, E, L, slices, in_ready, out_valid, busy}, 9'b100_010_010);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", {in_ready, busy, out_valid, G}, 4'b1001);

        // Abort on the second RUN cycle of an all-equal compare.
        wait_ready("abort");
        accept(8'hFF, 8'hFF, 1'b1);
        @(posedge clk); #1;
        check("abort_still_run", {busy, out_valid}, 2'b10);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", {in_ready, busy, out_valid, G, E, L}, 6'b100_000);
        run_op("after_abort", 8'hFF, 8'hFF, 3'b010, 4);

        // Abort coinciding with a terminating first-slice compare.
        accept(8'hC5, 8'h35, 1'b1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_wins", {in_ready, busy, out_valid, G, E, L}, 6'b100_000);
        @(posedge clk); #1;
        check("abort_wins_no_valid", out_valid, 0);

        // Asynchronous reset in the middle of a compare.
        accept(8'h01, 8'h02, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", {in_ready, out_valid, busy, G, E, L, slices}, 9'b100_000_000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_no_valid", {in_ready, out_valid}, 2'b10);
        run_op("01_02", 8'h01, 8'h02, 3'b001, 4);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
